// File: rtl/ifu_pcgen.sv
// Fetch PC generator: one outstanding imem request, branch-predicted next PC,
// and an in-order fetch queue feeding decode. Redirect flushes everything.
module ifu_pcgen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] bp_addr,
  input  logic        bp_hit,
  input  logic        bp_taken,
  input  logic [31:0] bp_paddr,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        dec_pred_taken,
  output logic [31:0] dec_pred_target,
  input  logic        dec_ready
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [31:0]     r_pc;
  logic [31:0]     r_lat_pc;
  logic            r_lat_tk;
  logic [31:0]     r_lat_tg;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_cnt;

  logic [31:0]     r_q_instr [QDEPTH];
  logic [31:0]     r_q_pc    [QDEPTH];
  logic            r_q_tk    [QDEPTH];
  logic [31:0]     r_q_tg    [QDEPTH];

  logic            w_accept;
  logic            w_pred_tk;
  logic            w_push;
  logic            w_pop;
  logic            w_room;

  assign w_room    = (r_cnt < CW'(QDEPTH));
  assign w_accept  = imem_req_valid && imem_req_ready;
  assign w_pred_tk = bp_hit & bp_taken;
  assign w_push    = (r_state == S_WAIT) && imem_rsp_valid && !redirect;
  assign w_pop     = dec_valid && dec_ready && !redirect;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_REQ;
    else     r_state <= w_next;
  end

  // A redirect turns an in-flight request into one whose reply is discarded.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_REQ: begin
        if (w_accept) w_next = redirect ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) w_next = S_REQ;
        else if (redirect)  w_next = S_DROP;
      end
      S_DROP: begin
        if (imem_rsp_valid) w_next = S_REQ;
      end
      default: w_next = S_REQ;
    endcase
  end

  always_comb begin
    bp_addr         = r_pc;
    imem_req_addr   = r_pc;
    imem_req_valid  = (r_state == S_REQ) && w_room && !rst;
    dec_valid       = (r_cnt != '0);
    dec_instr       = r_q_instr[r_rptr];
    dec_pc          = r_q_pc[r_rptr];
    dec_pred_taken  = r_q_tk[r_rptr];
    dec_pred_target = r_q_tg[r_rptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (redirect) begin
      r_pc <= redirect_pc;
    end else if (w_accept) begin
      r_pc <= w_pred_tk ? bp_paddr : r_pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lat_pc <= '0;
      r_lat_tk <= 1'b0;
      r_lat_tg <= '0;
    end else if (w_accept) begin
      r_lat_pc <= r_pc;
      r_lat_tk <= w_pred_tk;
      r_lat_tg <= w_pred_tk ? bp_paddr : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_wptr] <= imem_rsp_data;
      r_q_pc[r_wptr]    <= r_lat_pc;
      r_q_tk[r_wptr]    <= r_lat_tk;
      r_q_tg[r_wptr]    <= r_lat_tg;
    end
  end

endmodule

// File: tb/tb_ifu_pcgen.sv
// Scoreboard bench for ifu_pcgen: expected fetches queued as stimulus is set
// up, checked as requests are accepted and entries reach decode.
module tb_ifu_pcgen;

  logic        clk;
  logic        rst;
  logic [31:0] bp_addr;
  logic        bp_hit;
  logic        bp_taken;
  logic [31:0] bp_paddr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_pred_taken;
  logic [31:0] dec_pred_target;
  logic        dec_ready;

  ifu_pcgen #(
    .RESET_PC (32'h0000_0100),
    .QDEPTH   (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bp_addr         (bp_addr),
    .bp_hit          (bp_hit),
    .bp_taken        (bp_taken),
    .bp_paddr        (bp_paddr),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .dec_valid       (dec_valid),
    .dec_instr       (dec_instr),
    .dec_pc          (dec_pc),
    .dec_pred_taken  (dec_pred_taken),
    .dec_pred_target (dec_pred_target),
    .dec_ready       (dec_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        tk;
    logic [31:0] tg;
  } ent_t;

  logic [31:0] exp_req[$];
  ent_t        exp_dec[$];

  int n_cmp = 0;
  int n_bad = 0;

  int          grant = 0;
  int          lat = 1;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic        spur = 1'b0;

  logic        t_rst = 1'b1;
  logic        t_redir = 1'b0;
  logic [31:0] t_rpc = '0;
  logic        t_dready = 1'b1;

  logic        pr_en = 1'b0;
  logic [31:0] pr_addr = '0;
  logic        pr_taken = 1'b0;
  logic [31:0] pr_tgt = '0;

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic exp_fetch(logic [31:0] pc, logic tk, logic [31:0] tg);
    ent_t e;
    exp_req.push_back(pc);
    e.pc  = pc;
    e.ins = instr_of(pc);
    e.tk  = tk;
    e.tg  = tg;
    exp_dec.push_back(e);
  endtask

  task automatic tick();
    ent_t e;
    @(negedge clk);
    rst            = t_rst;
    redirect       = t_redir;
    redirect_pc    = t_rpc;
    dec_ready      = t_dready;
    imem_req_ready = (grant > 0);
    imem_rsp_valid = (pend_cnt == 1) || spur;
    imem_rsp_data  = spur ? instr_of(32'hBAD0) : instr_of(pend_addr);
    #1;
    bp_hit   = pr_en && (bp_addr == pr_addr);
    bp_taken = pr_taken;
    bp_paddr = pr_tgt;
    #1;
    if (imem_rsp_valid) pend_cnt = 0;
    else if (pend_cnt > 1) pend_cnt--;
    if (imem_req_valid && imem_req_ready) begin
      grant--;
      chk("req_avail", 32'(exp_req.size() > 0), 32'd1);
      if (exp_req.size() > 0) chk("req_addr", imem_req_addr, exp_req.pop_front());
      pend_cnt  = lat;
      pend_addr = imem_req_addr;
    end
    if (dec_valid && dec_ready && !redirect) begin
      chk("dec_avail", 32'(exp_dec.size() > 0), 32'd1);
      if (exp_dec.size() > 0) begin
        e = exp_dec.pop_front();
        chk("dec_pc", dec_pc, e.pc);
        chk("dec_instr", dec_instr, e.ins);
        chk("dec_tk", 32'(dec_pred_taken), 32'(e.tk));
        chk("dec_tg", dec_pred_target, e.tg);
      end
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic redir(logic [31:0] pc);
    t_redir = 1'b1;
    t_rpc   = pc;
    tick();
    t_redir = 1'b0;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
    bp_hit = 1'b0; bp_taken = 1'b0; bp_paddr = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    dec_ready = 1'b0;

    run(3);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_pc", bp_addr, 32'h100);

    // sequential fetch straight out of reset
    t_rst = 1'b0;
    grant = 3;
    exp_fetch(32'h100, 1'b0, 32'h0);
    exp_fetch(32'h104, 1'b0, 32'h0);
    exp_fetch(32'h108, 1'b0, 32'h0);
    run(12);

    // predicted taken at 0x104
    pr_en = 1'b1; pr_addr = 32'h104; pr_taken = 1'b1; pr_tgt = 32'h200;
    redir(32'h100);
    grant = 3;
    exp_fetch(32'h100, 1'b0, 32'h0);
    exp_fetch(32'h104, 1'b1, 32'h200);
    exp_fetch(32'h200, 1'b0, 32'h0);
    run(12);

    // hit but not taken
    pr_taken = 1'b0; pr_tgt = 32'h300;
    redir(32'h100);
    grant = 3;
    exp_fetch(32'h100, 1'b0, 32'h0);
    exp_fetch(32'h104, 1'b0, 32'h0);
    exp_fetch(32'h108, 1'b0, 32'h0);
    run(12);
    pr_en = 1'b0;

    // queue fills under decode backpressure
    t_dready = 1'b0;
    redir(32'h500);
    grant = 10;
    for (int i = 0; i < 4; i++) exp_fetch(32'h500 + 32'(4 * i), 1'b0, 32'h0);
    run(16);
    chk("full_stall", 32'(imem_req_valid), 32'd0);
    chk("full_head", dec_pc, 32'h500);
    exp_fetch(32'h510, 1'b0, 32'h0);
    t_dready = 1'b1;
    tick();
    t_dready = 1'b0;
    run(10);
    chk("full_stall2", 32'(imem_req_valid), 32'd0);
    chk("one_more", 32'(exp_req.size()), 32'd0);
    grant = 0;
    t_dready = 1'b1;
    run(12);

    // redirect while waiting on memory
    t_dready = 1'b0;
    redir(32'h600);
    grant = 1;
    exp_req.push_back(32'h600);
    run(4);
    chk("pre_flush_valid", 32'(dec_valid), 32'd1);
    lat = 2;
    grant = 1;
    exp_req.push_back(32'h604);
    tick();
    t_redir = 1'b1; t_rpc = 32'h400;
    tick();
    t_redir = 1'b0;
    tick();
    chk("flush_dec_valid", 32'(dec_valid), 32'd0);
    chk("drop_no_req", 32'(imem_req_valid), 32'd0);
    tick();
    chk("drop_no_push", 32'(dec_valid), 32'd0);
    chk("redir_pc", bp_addr, 32'h400);
    lat = 1;
    t_dready = 1'b1;
    grant = 1;
    exp_fetch(32'h400, 1'b0, 32'h0);
    run(6);

    // PC wrap, then redirect coincident with accept
    redir(32'hFFFF_FFFC);
    grant = 2;
    exp_fetch(32'hFFFF_FFFC, 1'b0, 32'h0);
    exp_fetch(32'h0000_0000, 1'b0, 32'h0);
    run(8);
    grant = 1;
    exp_req.push_back(32'h4);
    t_redir = 1'b1; t_rpc = 32'h700;
    tick();
    t_redir = 1'b0;
    tick();
    tick();
    chk("acc_redir_drop", 32'(dec_valid), 32'd0);
    grant = 1;
    exp_fetch(32'h700, 1'b0, 32'h0);
    run(6);

    // stray response while idle in REQ
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick();
    chk("spur_ignored", 32'(dec_valid), 32'd0);

    // reset with a request in flight
    lat = 2;
    grant = 1;
    exp_req.push_back(32'h704);
    tick();
    grant = 0;
    t_rst = 1'b1;
    tick();
    t_rst = 1'b0;
    tick();
    tick();
    chk("rst_rsp_ignored", 32'(dec_valid), 32'd0);
    chk("rst_pc2", bp_addr, 32'h100);

    chk("req_left", 32'(exp_req.size()), 32'd0);
    chk("dec_left", 32'(exp_dec.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifu_pcgen.md
IFU_PCGEN -- requirements
Module: ifu_pcgen

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, fetch address loaded on reset.
REQ-002 Parameter QDEPTH, 4, fetch-queue entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 bp_addr  output  32  current fetch PC presented to branch predictor lookup.
REQ-006 bp_hit  input  1  predictor hit for bp_addr, same cycle.
REQ-007 bp_taken  input  1  predictor taken for bp_addr, same cycle.
REQ-008 bp_paddr  input  32  predicted target for bp_addr, same cycle.
REQ-009 redirect  input  1  mispredict/flush from execute.
REQ-010 redirect_pc  input  32  corrected fetch address, valid with redirect.
REQ-011 imem_req_valid  output  1  fetch request valid.
REQ-012 imem_req_addr  output  32  fetch request address.
REQ-013 imem_req_ready  input  1  memory accepts request.
REQ-014 imem_rsp_valid  input  1  instruction word returned, in order, >=1 cycle after accept.
REQ-015 imem_rsp_data  input  32  instruction word.
REQ-016 dec_valid  output  1  queue head valid toward decode.
REQ-017 dec_instr / dec_pc  output  32 each  head instruction and its address.
REQ-018 dec_pred_taken / dec_pred_target  output  1 / 32  prediction captured for head.
REQ-019 dec_ready  input  1  decode consumes head.

Function
REQ-020 FSM states: REQ, WAIT, DROP; at most one request outstanding.
REQ-021 bp_addr and imem_req_addr SHALL equal PC register combinationally.
REQ-022 imem_req_valid = (state==REQ) && (count<QDEPTH) && !rst.
REQ-023 Accept = imem_req_valid && imem_req_ready; on accept latch PC, pred_taken=bp_hit&bp_taken, pred_target=(pred_taken?bp_paddr:0); state->WAIT.
REQ-024 On accept, PC <= (bp_hit&&bp_taken) ? bp_paddr : PC+4, modulo 2^32 (0xFFFFFFFC+4 = 0x0).
REQ-025 WAIT with imem_rsp_valid: push {rsp_data, latched PC, latched pred} to queue; state->REQ.
REQ-026 DROP with imem_rsp_valid: discard response, no push; state->REQ.
REQ-027 imem_rsp_valid in REQ state SHALL be ignored.
REQ-028 Queue: FIFO, head on dec_* outputs; pop when dec_valid&&dec_ready; push and pop same cycle leaves count unchanged.
REQ-029 Push never occurs at full: request issue guarantees a free slot.
REQ-030 redirect has priority over all same-cycle events: PC <= redirect_pc, queue cleared (count=0, dec_valid=0 next cycle), no push, no pop effect.
REQ-031 redirect next state: WAIT->DROP; WAIT with same-cycle imem_rsp_valid->REQ; REQ with same-cycle accept->DROP; REQ otherwise->REQ; DROP with imem_rsp_valid->REQ, else DROP.
REQ-032 Prediction inputs sampled only in accept cycle; ignored otherwise.

Reset
REQ-033 While rst high: PC=RESET_PC, state=REQ, count=0, read/write pointers 0, imem_req_valid=0, dec_valid=0.
REQ-034 rst mid-request: outstanding response arriving after rst deassert SHALL be discarded if it arrives in REQ state (per REQ-027); memory is reset alongside.
REQ-035 First request issued in the cycle rst deasserts, at RESET_PC.

Verification
REQ-036 RESET_PC=0x100, ready=1, rsp 1 cycle later, bp_hit=0 -> requests 0x100,0x104,0x108; dec_pc same order, pred_taken=0.
REQ-037 bp_hit=1,bp_taken=1,bp_paddr=0x200 at accept of 0x104 -> next request 0x200; entry 0x104 has pred_taken=1, target 0x200.
REQ-038 bp_hit=1,bp_taken=0 at 0x104 -> next request 0x108, pred_taken=0.
REQ-039 dec_ready=0 -> after 4 pushes imem_req_valid=0; one pop -> exactly one further request.
REQ-040 redirect=1, redirect_pc=0x400 in WAIT -> dec_valid=0 next cycle, next response dropped, next request 0x400.
REQ-041 PC=0xFFFFFFFC, no prediction -> next request 0x00000000; redirect coincident with accept -> that response dropped.
